// File: rtl/present_sbox_layer_masked.sv
// Two-share masked PRESENT S-box layer: NSBOX parallel lanes, one gadget register stage,
// valid/ready handshake with stall support and an optional share-wise output register.
module present_sbox_layer_masked #(
  parameter int NSBOX   = 16,
  parameter int OUT_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NSBOX-1:0]   in_share0,
  input  logic [4*NSBOX-1:0]   in_share1,
  input  logic [8*NSBOX-1:0]   ran,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NSBOX-1:0]   out_share0,
  output logic [4*NSBOX-1:0]   out_share1
);

  localparam int W  = 4 * NSBOX;
  localparam int GW = 24;

  // ANF of the S-box: per output bit, one 16-bit monomial set (index = variable subset,
  // bit0 = a .. bit3 = d). Linear monomials live in LIN_ANF, the affine constant in AFF.
  localparam logic [63:0] NL_ANF  = 64'h28C0_2E08_3C80_0040;
  localparam logic [15:0] LIN_ANF = 16'hBCAD;
  localparam logic [3:0]  AFF     = 4'hC;

  typedef struct packed {
    logic [3:0] lin0;
    logic [3:0] lin1;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] cx0;
    logic [3:0] cx1;
  } gadget_t;

  // Product of the variables in m, taking each from share k[v].
  function automatic logic mono(input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] m, input logic [3:0] k);
    logic p;
    p = 1'b1;
    for (int v = 0; v < 4; v++)
      if (m[v]) p = p & (k[v] ? s1[v] : s0[v]);
    return p;
  endfunction

  // Cross-domain products are split by the share index of their lowest variable and
  // blinded with r[j]; r[4+j] re-masks the share-0 inner sum against the share-1 cross sum.
  function automatic gadget_t first_half(input logic [3:0] s0, input logic [3:0] s1,
                                         input logic [7:0] r);
    gadget_t    g;
    logic [3:0] m4;
    logic [3:0] k4;
    int         lo;
    g = '0;
    for (int j = 0; j < 4; j++) begin
      for (int v = 0; v < 4; v++)
        if (LIN_ANF[4*j+v]) begin
          g.lin0[j] = g.lin0[j] ^ s0[v];
          g.lin1[j] = g.lin1[j] ^ s1[v];
        end
      g.lin0[j] = g.lin0[j] ^ AFF[j];
      for (int m = 0; m < 16; m++) begin
        m4 = 4'(m);
        lo = 0;
        for (int v = 3; v >= 0; v--)
          if (m4[v]) lo = v;
        if (NL_ANF[16*j+m]) begin
          for (int k = 0; k < 16; k++) begin
            k4 = 4'(k);
            if ((k4 & ~m4) == 4'h0) begin
              if (k4 == 4'h0)      g.in0[j] = g.in0[j] ^ mono(s0, s1, m4, k4);
              else if (k4 == m4)   g.in1[j] = g.in1[j] ^ mono(s0, s1, m4, k4);
              else if (k4[lo])     g.cx1[j] = g.cx1[j] ^ mono(s0, s1, m4, k4);
              else                 g.cx0[j] = g.cx0[j] ^ mono(s0, s1, m4, k4);
            end
          end
        end
      end
      g.cx0[j] = g.cx0[j] ^ r[j];
      g.cx1[j] = g.cx1[j] ^ r[j] ^ r[4+j];
      g.in0[j] = g.in0[j] ^ r[4+j];
    end
    return g;
  endfunction

  logic              v1_q, v1_d, v2_q, v2_d;
  logic              accept, load2, leave1;
  logic [GW*NSBOX-1:0] st_q, st_d;
  logic [W-1:0]      o0_q, o0_d, o1_q, o1_d;
  logic [W-1:0]      g0, g1;
  gadget_t           g_lane;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load2     = 1'b0;
    v2_d      = 1'b0;
    leave1    = 1'b0;
    if (OUT_REG != 0) begin
      load2     = v1_q & (~v2_q | out_ready);
      v2_d      = load2 | (v2_q & ~out_ready);
      leave1    = load2;
      out_valid = v2_q;
    end else begin
      leave1    = out_ready;
      out_valid = v1_q;
    end
    in_ready = ~v1_q | leave1;
    accept   = in_valid & in_ready;
    v1_d     = accept | (v1_q & ~leave1);
  end

  always_comb begin
    st_d = st_q;
    if (accept)
      for (int i = 0; i < NSBOX; i++)
        st_d[GW*i +: GW] = first_half(in_share0[4*i +: 4], in_share1[4*i +: 4], ran[8*i +: 8]);
  end

  // Second gadget half: share-wise recombination of registered terms only.
  always_comb begin
    g0     = '0;
    g1     = '0;
    g_lane = '0;
    for (int i = 0; i < NSBOX; i++) begin
      g_lane        = st_q[GW*i +: GW];
      g0[4*i +: 4]  = g_lane.lin0 ^ g_lane.in0 ^ g_lane.cx0;
      g1[4*i +: 4]  = g_lane.lin1 ^ g_lane.in1 ^ g_lane.cx1;
    end
  end

  always_comb begin
    o0_d = o0_q;
    o1_d = o1_q;
    if (load2) begin
      o0_d = g0;
      o1_d = g1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      st_q <= '0;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      st_q <= st_d;
      o0_q <= o0_d;
      o1_q <= o1_d;
    end
  end

  assign out_share0 = (OUT_REG != 0) ? o0_q : g0;
  assign out_share1 = (OUT_REG != 0) ? o1_q : g1;

endmodule
